// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit shifter (logical, arithmetic, rotate)
// among NREQ requesters; the result lands in a single registered output slot.
module shift_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_in,
  input  logic [NREQ*3-1:0] req_op,
  input  logic [NREQ*5-1:0] req_cnt,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a requester holds valid and payload until then, and ready never waits on valid
  // of the same requester except to pick the round-robin winner.

  logic [31:0]    in_arr  [NREQ];
  logic [2:0]     op_arr  [NREQ];
  logic [4:0]     cnt_arr [NREQ];
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic [IDW:0]   sum;
  logic           found;
  logic           free;
  logic           accept;

  function automatic logic [31:0] shift_fn(input logic [31:0] a, input logic [2:0] op,
                                           input logic [4:0] cnt);
    logic [63:0] dbl;
    logic [63:0] tmp;
    dbl = {a, a};
    tmp = '0;
    case (op)
      3'd0, 3'd2: shift_fn = a << cnt;
      3'd1:       shift_fn = a >> cnt;
      3'd3:       shift_fn = 32'($signed(a) >>> cnt);
      3'd4: begin
        tmp      = dbl << cnt;
        shift_fn = tmp[63:32];
      end
      3'd5: begin
        tmp      = dbl >> cnt;
        shift_fn = tmp[31:0];
      end
      default:    shift_fn = '0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      in_arr[i]  = req_in[32*i +: 32];
      op_arr[i]  = req_op[3*i +: 3];
      cnt_arr[i] = req_cnt[5*i +: 5];
    end
  end

  // Search starts at rr_ptr and wraps modulo NREQ; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign free   = !resp_valid || resp_ready;
  assign accept = rst_n && found && free;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      rr_ptr     <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_id    <= win;
      resp_data  <= shift_fn(in_arr[win], op_arr[win], cnt_arr[win]);
      resp_err   <= (op_arr[win] >= 3'd6);
      rr_ptr     <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares on every output handshake.
module tb_shift_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_in;
  logic [NREQ*3-1:0] req_op;
  logic [NREQ*5-1:0] req_cnt;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [IDW-1:0]    resp_id;
  logic              resp_err;

  logic [IDW+32:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] din [4];
  logic [2:0]  op_tab  [12];
  logic [4:0]  cnt_tab [12];
  logic [31:0] res_tab [12];
  logic        err_tab [12];

  shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in(req_in), .req_op(req_op), .req_cnt(req_cnt),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [34:0] mk(input logic err, input logic [1:0] id, input logic [31:0] d);
    return {err, id, d};
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL resp_unexpected: got %h want none", {resp_err, resp_id, resp_data});
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        check("resp", {resp_err, resp_id, resp_data}, e);
      end
    end
  end

  // driver tasks
  task automatic set_req(input int i, input logic [31:0] d, input logic [2:0] op,
                         input logic [4:0] cnt);
    req_in[32*i +: 32] = d;
    req_op[3*i +: 3]   = op;
    req_cnt[5*i +: 5]  = cnt;
  endtask

  task automatic step(input string name, input logic [3:0] v, input logic rr,
                      input logic [3:0] exp_rdy, input logic exp_rv, input logic [34:0] exp_resp);
    req_valid  = v;
    resp_ready = rr;
    @(negedge clk);
    check({name, "_ready"}, 35'(req_ready), 35'(exp_rdy));
    check({name, "_valid"}, 35'(resp_valid), 35'(exp_rv));
    if (exp_rdy != 4'b0000) exp_q.push_back(exp_resp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    din[0] = 32'hA0A0_0000;
    din[1] = 32'h0000_1234;
    din[2] = 32'h8000_0001;
    din[3] = 32'h3333_0003;
    op_tab  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd5, 3'd4, 3'd1, 3'd3};
    cnt_tab = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd1, 5'd1, 5'd0, 5'd3, 5'd0, 5'd31, 5'd31, 5'd31};
    res_tab = '{32'h0000_0010, 32'h0800_0000, 32'h0000_0010, 32'hF800_0000,
                32'h0000_0003, 32'hC000_0000, 32'h0000_0000, 32'h0000_0000,
                32'h8000_0001, 32'hC000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    err_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n      = 1'b0;
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    req_in     = '0;
    req_op     = '0;
    req_cnt    = '0;
    for (int i = 0; i < 4; i++) set_req(i, din[i], 3'd0, 5'd0);

    // reset with every request raised
    @(negedge clk);
    check("rst_valid", 35'(resp_valid), 35'(0));
    check("rst_ready", 35'(req_ready), 35'(0));
    check("rst_slot", {resp_err, resp_id, resp_data}, 35'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // round-robin under continuous drain
    for (int k = 0; k < 8; k++) begin
      int id;
      id = k % 4;
      step("rr", 4'hF, 1'b1, 4'(1 << id), (k != 0), mk(1'b0, 2'(id), din[id]));
    end
    step("idle", 4'h0, 1'b1, 4'h0, 1'b1, '0);

    // every op through requester 2
    for (int j = 0; j < 12; j++) begin
      set_req(2, 32'h8000_0001, op_tab[j], cnt_tab[j]);
      step("op", 4'b0100, 1'b1, 4'b0100, (j != 0), mk(err_tab[j], 2'd2, res_tab[j]));
    end
    set_req(2, din[2], 3'd0, 5'd0);
    step("idle", 4'h0, 1'b1, 4'h0, 1'b1, '0);

    // backpressure: slot holds id1 while requests wait
    step("bp_fill", 4'b0010, 1'b0, 4'b0010, 1'b0, mk(1'b0, 2'd1, 32'h1234));
    for (int k = 0; k < 3; k++) begin
      step("bp_hold", 4'b1010, 1'b0, 4'b0000, 1'b1, '0);
      check("bp_slot", {resp_err, resp_id, resp_data}, mk(1'b0, 2'd1, 32'h1234));
    end
    step("bp_release", 4'b1010, 1'b1, 4'b1000, 1'b1, mk(1'b0, 2'd3, din[3]));
    step("refill", 4'b0010, 1'b1, 4'b0010, 1'b1, mk(1'b0, 2'd1, 32'h1234));
    step("pend", 4'b0000, 1'b0, 4'b0000, 1'b1, '0);

    // asynchronous reset between edges discards the pending result
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 35'(resp_valid), 35'(0));
    check("mid_rst_slot", {resp_err, resp_id, resp_data}, 35'(0));
    void'(exp_q.pop_back());
    #1;
    rst_n = 1'b1;
    step("post_rst", 4'hF, 1'b1, 4'b0001, 1'b0, mk(1'b0, 2'd0, din[0]));

    // wrap and skip with only requesters 0 and 3
    for (int k = 0; k < 4; k++) begin
      int id;
      id = (k % 2 == 0) ? 3 : 0;
      step("wrap", 4'b1001, 1'b1, (id == 3) ? 4'b1000 : 4'b0001, 1'b1,
           mk(1'b0, 2'(id), din[id]));
    end
    step("drain", 4'h0, 1'b1, 4'h0, 1'b1, '0);
    step("empty", 4'h0, 1'b1, 4'h0, 1'b0, '0);
    check("q_empty", 35'(exp_q.size()), 35'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
